subleq_ctrl: RTL and testbench

SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

---
 rtl/subleq_pkg.sv | 20 ++
 rtl/subleq_alu.sv | 16 +
 rtl/subleq_ctrl.sv | 136 +++++++++++++
 tb/tb_subleq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ controller.
//   state_e   : controller sequencing states (six per instruction plus halt)
//   HALT_ADDR : branch target that halts the controller when halting is built in
//   INSTR_LEN : bytes per instruction (A, B, C)
package subleq_pkg;

  typedef enum logic [2:0] {
    S_FA,
    S_FB,
    S_FC,
    S_RA,
    S_RB,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [7:0] HALT_ADDR = 8'hFF;
  localparam logic [7:0] INSTR_LEN = 8'd3;

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ datapath: res = mem[B] - mem[A] (8-bit wrap) and the "result <= 0" flag.
//   i_mb  : operand mem[B]
//   i_ma  : operand mem[A]
//   o_res : difference, overflow ignored
//   o_leq : high when o_res is negative (two's complement) or zero
module subleq_alu (
  input  logic [7:0] i_mb,
  input  logic [7:0] i_ma,
  output logic [7:0] o_res,
  output logic       o_leq
);

  assign o_res = i_mb - i_ma;
  assign o_leq = o_res[7] | (o_res == 8'h00);

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ single-instruction CPU controller. Each instruction takes six cycles:
// fetch A, B, C, read mem[A], read mem[B], write mem[B] and branch.
// Memory has one cycle of read latency, so each state latches the data
// requested by the previous state.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_run            : permits a new instruction to start (sampled in S_FA only)
//   o_raddr/i_rdata  : memory read port (data returns one cycle later)
//   o_waddr/o_wdata/o_we : memory write port, o_we pulses once per instruction
//   o_pc, o_icount   : program counter, retired-instruction count
//   o_halt           : controller halted
// Build option: define SUBLEQ_CTRL_HALT_EN to halt on a taken branch to 8'hFF;
// otherwise such a branch executes normally and o_halt is tied low.
module subleq_ctrl
  import subleq_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  output logic [7:0]  o_raddr,
  input  logic [7:0]  i_rdata,
  output logic [7:0]  o_waddr,
  output logic [7:0]  o_wdata,
  output logic        o_we,
  output logic [7:0]  o_pc,
  output logic [15:0] o_icount,
  output logic        o_halt
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] icount_q, icount_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  c_q, c_d;
  logic [7:0]  ma_q, ma_d;

  logic [7:0]  res;
  logic        leq;

  // In S_WB, i_rdata holds mem[B] requested during S_RB.
  subleq_alu u_alu (
    .i_mb  (i_rdata),
    .i_ma  (ma_q),
    .o_res (res),
    .o_leq (leq)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    ma_d     = ma_q;
    o_raddr  = pc_q;
    o_waddr  = b_q;
    o_wdata  = 8'h00;
    o_we     = 1'b0;

    unique case (state_q)
      S_FA: begin
        o_raddr = pc_q;
        if (i_run) state_d = S_FB;
      end
      S_FB: begin
        a_d     = i_rdata;
        o_raddr = pc_q + 8'd1;
        state_d = S_FC;
      end
      S_FC: begin
        b_d     = i_rdata;
        o_raddr = pc_q + 8'd2;
        state_d = S_RA;
      end
      S_RA: begin
        c_d     = i_rdata;
        o_raddr = a_q;
        state_d = S_RB;
      end
      S_RB: begin
        ma_d    = i_rdata;
        o_raddr = b_q;
        state_d = S_WB;
      end
      S_WB: begin
        o_we     = 1'b1;
        o_wdata  = res;
        icount_d = icount_q + 16'd1;
        pc_d     = leq ? c_q : pc_q + INSTR_LEN;
        state_d  = S_FA;
`ifdef SUBLEQ_CTRL_HALT_EN
        if (leq && (c_q == HALT_ADDR)) state_d = S_HALT;
`endif
      end
      S_HALT: begin
        o_raddr = pc_q;
      end
      default: begin
        state_d = S_FA;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_FA;
      pc_q     <= RESET_PC;
      icount_q <= 16'h0000;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 8'h00;
      ma_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      ma_q     <= ma_d;
    end
  end

  assign o_pc     = pc_q;
  assign o_icount = icount_q;

`ifdef SUBLEQ_CTRL_HALT_EN
  assign o_halt = (state_q == S_HALT);
`else
  assign o_halt = 1'b0;
`endif

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: directed literal scenarios plus a randomized phase
// checked every cycle against an instruction-level SUBLEQ model.
module tb_subleq_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_run = 1'b0;
  logic [7:0]  o_raddr;
  logic [7:0]  rdata;
  logic [7:0]  o_waddr;
  logic [7:0]  o_wdata;
  logic        o_we;
  logic [7:0]  o_pc;
  logic [15:0] o_icount;
  logic        o_halt;

  always #5 clk = ~clk;

  subleq_ctrl #(
    .RESET_PC (8'h00)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_run    (i_run),
    .o_raddr  (o_raddr),
    .i_rdata  (rdata),
    .o_waddr  (o_waddr),
    .o_wdata  (o_wdata),
    .o_we     (o_we),
    .o_pc     (o_pc),
    .o_icount (o_icount),
    .o_halt   (o_halt)
  );

  // Synchronous memory with one-cycle read latency; img is bulk-loaded on load.
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (o_we) begin
      mem[o_waddr] <= o_wdata;
    end
    rdata <= mem[o_raddr];
  end

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  // Loads img during reset; returns one time unit into the first S_FA cycle.
  task automatic do_reset(input logic run);
    i_run = run;
    i_rst = 1'b1;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(posedge clk);
    #1 i_rst = 1'b0;
  endtask

  // Counts negedges until o_we is seen; returns at the negedge of the write cycle.
  task automatic wait_we(input int max, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      n++;
      if (o_we) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("we_timeout", 32'd0, 32'd1);
      n = -1;
    end
  endtask

  // Instruction-level reference model, checked every cycle while chk_en is set.
  logic [7:0]  ref_mem [256];
  logic [7:0]  m_pc;
  logic [15:0] m_ic;
  bit          m_halt;
  int          gap;
  bit          run_hold;

  initial begin
    logic [7:0] ma, mb, mc, res;
    bit taken;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        m_pc = 8'h00;
        m_ic = 16'h0000;
        m_halt = 1'b0;
        gap = 0;
        run_hold = 1'b1;
      end else begin
        chk("m_pc", {24'd0, o_pc}, {24'd0, m_pc});
        chk("m_icount", {16'd0, o_icount}, {16'd0, m_ic});
        chk("m_halt", {31'd0, o_halt}, {31'd0, m_halt});
        if (m_halt) begin
          chk("m_halt_we", {31'd0, o_we}, 32'd0);
          chk("m_halt_raddr", {24'd0, o_raddr}, {24'd0, m_pc});
        end
        gap++;
        if (o_we) begin
          ma  = ref_mem[ref_mem[m_pc]];
          mb  = ref_mem[ref_mem[8'(m_pc + 8'd1)]];
          mc  = ref_mem[8'(m_pc + 8'd2)];
          res = 8'(mb - ma);
          chk("m_waddr", {24'd0, o_waddr}, {24'd0, ref_mem[8'(m_pc + 8'd1)]});
          chk("m_wdata", {24'd0, o_wdata}, {24'd0, res});
          if (run_hold) chk("m_gap_exact", gap, 6);
          else chk("m_gap_min", {31'd0, gap >= 6}, 32'd1);
          ref_mem[ref_mem[8'(m_pc + 8'd1)]] = res;
          if (!i_rst) begin
            taken = (res == 8'h00) || ($signed(res) < 0);
            m_ic = m_ic + 16'd1;
            m_pc = taken ? mc : 8'(m_pc + 8'd3);
`ifdef SUBLEQ_CTRL_HALT_EN
            if (taken && mc == 8'hFF) m_halt = 1'b1;
`endif
          end
          gap = 0;
          run_hold = 1'b1;
        end else begin
          chk("m_wdata_idle", {24'd0, o_wdata}, 32'd0);
          if (!i_run) run_hold = 1'b0;
        end
        if (i_rst) begin
          m_pc = 8'h00;
          m_ic = 16'h0000;
          m_halt = 1'b0;
          gap = 0;
          run_hold = 1'b1;
        end
      end
    end
  end

  // Writes program {a, b, c} at address 0 and two data bytes.
  task automatic prog(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] va, input logic [7:0] vb);
    clear_img();
    img[0] = a;
    img[1] = b;
    img[2] = c;
    img[a] = va;
    img[b] = vb;
  endtask

  initial begin
    int n;
    logic [7:0] r0, r1, r2;

    // Basic instruction, fall-through.
    prog(8'd10, 8'd11, 8'd3, 8'd2, 8'd5);
    do_reset(1'b1);
    chk("rst_pc", {24'd0, o_pc}, 32'h0);
    chk("rst_icount", {16'd0, o_icount}, 32'h0);
    chk("rst_halt", {31'd0, o_halt}, 32'h0);
    wait_we(20, n);
    i_run = 1'b0;
    chk("t1_cycle", n, 6);
    chk("t1_waddr", {24'd0, o_waddr}, 32'd11);
    chk("t1_wdata", {24'd0, o_wdata}, 32'd3);
    @(posedge clk);
    #1;
    chk("t1_pc", {24'd0, o_pc}, 32'd3);
    chk("t1_icount", {16'd0, o_icount}, 32'd1);
    chk("t1_mem", {24'd0, mem[11]}, 32'd3);

    // Zero result takes the branch.
    prog(8'd10, 8'd11, 8'h20, 8'd5, 8'd5);
    do_reset(1'b1);
    wait_we(20, n);
    i_run = 1'b0;
    chk("t2_wdata", {24'd0, o_wdata}, 32'd0);
    @(posedge clk);
    #1;
    chk("t2_pc", {24'd0, o_pc}, 32'h20);
    chk("t2_mem", {24'd0, mem[11]}, 32'd0);

    // Branch to FE, then an instruction straddling the address wrap.
    prog(8'd10, 8'd11, 8'hFE, 8'd9, 8'd9);
    img[8'hFE] = 8'd12;
    img[8'hFF] = 8'd13;
    img[12] = 8'd1;
    img[13] = 8'd5;
    do_reset(1'b1);
    wait_we(20, n);
    chk("t3_wdata0", {24'd0, o_wdata}, 32'd0);
    @(posedge clk);
    #1;
    chk("t3_pc_fe", {24'd0, o_pc}, 32'hFE);
    @(negedge clk) r0 = o_raddr;
    @(negedge clk) r1 = o_raddr;
    @(negedge clk) r2 = o_raddr;
    chk("t3_raddr0", {24'd0, r0}, 32'hFE);
    chk("t3_raddr1", {24'd0, r1}, 32'hFF);
    chk("t3_raddr2", {24'd0, r2}, 32'h00);
    wait_we(10, n);
    i_run = 1'b0;
    chk("t3_waddr", {24'd0, o_waddr}, 32'd13);
    chk("t3_wdata", {24'd0, o_wdata}, 32'd4);
    @(posedge clk);
    #1;
    chk("t3_pc_wrap", {24'd0, o_pc}, 32'h01);
    chk("t3_icount", {16'd0, o_icount}, 32'd2);

    // Idle with i_run low, then start.
    prog(8'd10, 8'd11, 8'd3, 8'd2, 8'd5);
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_idle_raddr", {24'd0, o_raddr}, 32'h0);
      chk("t4_idle_we", {31'd0, o_we}, 32'h0);
      chk("t4_idle_icount", {16'd0, o_icount}, 32'h0);
    end
    @(posedge clk);
    #1 i_run = 1'b1;
    wait_we(20, n);
    i_run = 1'b0;
    chk("t4_start_cycle", n, 6);

    // Branch to FF: halts when built in, otherwise keeps executing.
    prog(8'd10, 8'd10, 8'hFF, 8'd7, 8'd7);
    do_reset(1'b1);
    wait_we(20, n);
    chk("t5_waddr", {24'd0, o_waddr}, 32'd10);
    chk("t5_wdata", {24'd0, o_wdata}, 32'd0);
    @(posedge clk);
    #1;
    chk("t5_pc", {24'd0, o_pc}, 32'hFF);
`ifdef SUBLEQ_CTRL_HALT_EN
    chk("t5_halt", {31'd0, o_halt}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_halt_we", {31'd0, o_we}, 32'd0);
      chk("t5_halt_raddr", {24'd0, o_raddr}, 32'hFF);
    end
    chk("t5_halt_pc", {24'd0, o_pc}, 32'hFF);
    chk("t5_halt_icount", {16'd0, o_icount}, 32'd1);
`else
    chk("t5_nohalt", {31'd0, o_halt}, 32'd0);
    @(negedge clk);
    chk("t5_fetch_ff", {24'd0, o_raddr}, 32'hFF);
`endif
    i_run = 1'b0;

    // Reset during S_RB aborts the instruction.
    prog(8'd10, 8'd11, 8'd3, 8'd2, 8'd5);
    do_reset(1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_rb_raddr", {24'd0, o_raddr}, 32'd11);
    i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    i_run = 1'b0;
    chk("t6_pc", {24'd0, o_pc}, 32'h0);
    chk("t6_raddr", {24'd0, o_raddr}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_we", {31'd0, o_we}, 32'd0);
    end
    chk("t6_icount", {16'd0, o_icount}, 32'd0);
    chk("t6_mem", {24'd0, mem[11]}, 32'd5);

    // Reset during S_WB: write still lands, PC/count update suppressed.
    do_reset(1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t7_wb_we", {31'd0, o_we}, 32'd1);
    i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    i_run = 1'b0;
    chk("t7_pc", {24'd0, o_pc}, 32'h0);
    chk("t7_icount", {16'd0, o_icount}, 32'd0);
    chk("t7_mem", {24'd0, mem[11]}, 32'd3);

    // Randomized programs against the model.
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      i_run = 1'b1;
      i_rst = 1'b1;
      load  = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk);
      #1 i_rst = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(posedge clk);
        #1;
        i_run = (round < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        i_rst = ($urandom_range(0, 199) == 0);
      end
      @(posedge clk);
      #1 i_rst = 1'b0;
      chk_en = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
